// File: rtl/stream_time_gate_pkg.sv
// Shared definitions for the stream time gate: FSM state encoding,
// default widths and the field layout of an input word
// ({timestamp, payload}, payload in the low bits).
package stream_time_gate_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIME_WIDTH = 32;

  // Payload occupies the low DATA_WIDTH bits of an input word.
  localparam int PAYLOAD_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_ERROR = 3'd3,
    ST_END   = 3'd4
  } gate_state_e;

  // Timestamp field sits directly above the payload.
  function automatic int ts_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int ts_msb(input int data_width, input int time_width);
    return data_width + time_width - 1;
  endfunction

endpackage

// File: rtl/stream_time_gate_counter.sv
// Run-time counter for the stream time gate: synchronous clear, count
// enable, saturates at all-ones (never wraps) and flags that terminal value.
module time_gate_counter
  import stream_time_gate_pkg::*;
#(
  parameter int WIDTH = DEF_TIME_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_end
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign count  = count_q;
  assign at_end = &count_q;

  // Next count: clear wins, then increment unless already at the terminal value.
  always_comb begin
    if (clr) begin
      count_d = '0;
    end else if (en && !at_end) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stream_time_gate.sv
// Stream time gate: holds one timed word and releases its payload as a
// single-cycle strobe when the run-time counter equals its timestamp.
// Optional build macro TIME_GATE_LATE_CHECK_EN: a held word whose timestamp
// is already behind the counter sends the block to ERROR instead of being
// released late.
module stream_time_gate
  import stream_time_gate_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIME_WIDTH = DEF_TIME_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           run,
  input  logic                           clear,
  input  logic [TIME_WIDTH+DATA_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_strobe,
  output logic [TIME_WIDTH-1:0]          time_count,
  output logic                           status_running,
  output logic                           status_error,
  output logic                           status_end
);

  localparam int TS_LSB = ts_lsb(DATA_WIDTH);
  localparam int TS_MSB = ts_msb(DATA_WIDTH, TIME_WIDTH);

  gate_state_e state_q, state_d;

  logic                  hold_valid_q, hold_valid_d;
  logic [TIME_WIDTH-1:0] hold_time_q, hold_time_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_strobe_q, out_strobe_d;

  logic [TIME_WIDTH-1:0] count;
  logic                  count_at_end;
  logic                  count_en;
  logic [TIME_WIDTH-1:0] word_time;
  logic [DATA_WIDTH-1:0] word_data;
  logic                  running, match, behind, late, release_now, accept;

  assign word_time = in_data[TS_MSB:TS_LSB];
  assign word_data = in_data[PAYLOAD_LSB +: DATA_WIDTH];

  assign running = (state_q == ST_RUN);
  assign match   = running && hold_valid_q && (hold_time_q == count);
  assign behind  = running && hold_valid_q && (hold_time_q < count);

`ifdef TIME_GATE_LATE_CHECK_EN
  assign late        = behind;
  assign release_now = match;
`else
  // Without the late check a stale word simply goes out on the next RUN cycle.
  assign late        = 1'b0;
  assign release_now = match || behind;
`endif

  assign accept   = in_valid && in_ready;
  assign count_en = running && !late;

  time_gate_counter #(.WIDTH(TIME_WIDTH)) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clr    (clear),
    .en     (count_en),
    .count  (count),
    .at_end (count_at_end)
  );

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; clear overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = run ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (late) begin
            state_d = ST_ERROR;
          end else if (count_at_end) begin
            state_d = ST_END;
          end else if (!run) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: state_d = run ? ST_RUN : ST_PAUSE;
        ST_ERROR: state_d = ST_ERROR;
        ST_END:   state_d = ST_END;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: ready depends on registers only, never on in_valid.
  always_comb begin
    in_ready       = 1'b0;
    status_running = 1'b0;
    status_error   = 1'b0;
    status_end     = 1'b0;
    case (state_q)
      ST_IDLE, ST_PAUSE: in_ready = !hold_valid_q;
      ST_RUN: begin
        in_ready       = !hold_valid_q || release_now;
        status_running = 1'b1;
      end
      ST_ERROR: begin
`ifdef TIME_GATE_LATE_CHECK_EN
        status_error = 1'b1;
`endif
      end
      ST_END:  status_end = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Holding register and release path; a release and a load may share an edge.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_time_d  = hold_time_q;
    hold_data_d  = hold_data_q;
    out_data_d   = out_data_q;
    out_strobe_d = 1'b0;
    if (clear) begin
      hold_valid_d = 1'b0;
    end else begin
      if (release_now) begin
        out_data_d   = hold_data_q;
        out_strobe_d = 1'b1;
      end else begin
        out_data_d = out_data_q;
      end
      if (accept) begin
        hold_valid_d = 1'b1;
        hold_time_d  = word_time;
        hold_data_d  = word_data;
      end else if (release_now) begin
        hold_valid_d = 1'b0;
      end else begin
        hold_valid_d = hold_valid_q;
      end
    end
  end

  // Holding and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_time_q  <= '0;
      hold_data_q  <= '0;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_time_q  <= hold_time_d;
      hold_data_q  <= hold_data_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_strobe = out_strobe_q;
  assign time_count = count;

endmodule
